seq_det_ctrl: RTL and testbench

Run-time controller for the serial pattern detector path. It holds a programmable pattern, length and overlap mode, and arms detection over a bounded bit window. It counts matches against a threshold and reports completion to the host. It replaces hard-wired single-pattern Moore detectors with one configurable, sequenced engine.

---
 rtl/seq_det_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_seq_det_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_ctrl.sv
// rtl/seq_det_ctrl.sv - configurable serial pattern detector run controller (optional irq via SEQ_DET_IRQ_EN)
module seq_det_ctrl #(
    parameter int PAT_W = 8,
    parameter int WIN_W = 12,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_we,
    input  logic [PAT_W-1:0]           cfg_pattern,
    input  logic [$clog2(PAT_W+1)-1:0] cfg_len,
    input  logic                       cfg_overlap,
    input  logic [WIN_W-1:0]           cfg_window,
    input  logic [CNT_W-1:0]           cfg_thresh,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       bit_valid,
    input  logic                       bit_in,
    output logic                       busy,
    output logic                       done,
    output logic                       match,
    output logic                       hit,
    output logic [CNT_W-1:0]           match_count,
    output logic                       err
`ifdef SEQ_DET_IRQ_EN
    ,
    input  logic                       irq_clr,
    output logic                       irq
`endif
);

    localparam int LEN_W = $clog2(PAT_W + 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;

    // Shadow configuration, frozen while a run is active
    logic [PAT_W-1:0]   pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    logic [WIN_W-1:0]   win_q;
    logic [CNT_W-1:0]   thr_q;
    logic               cfg_take;

    logic [PAT_W-1:0]   hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [WIN_W-1:0]   bits_q, bits_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               match_q, match_d;
    logic               hit_q, hit_d;
    logic               err_q, err_d;

    logic [PAT_W-1:0]   mask;
    logic [PAT_W-1:0]   hist_shift;
    logic [LEN_W-1:0]   fill_inc;
    logic               pat_hit;

    // Next-state and datapath update: run sequencing, history shift, match counting
    always_comb begin
        state_d    = state_q;
        hist_d     = hist_q;
        fill_d     = fill_q;
        bits_d     = bits_q;
        cnt_d      = cnt_q;
        match_d    = 1'b0;
        hit_d      = hit_q;
        err_d      = err_q;
        cfg_take   = 1'b0;
        mask       = {PAT_W{1'b1}} >> (LEN_MAX - len_q);
        hist_shift = {hist_q[PAT_W-2:0], bit_in};
        fill_inc   = (fill_q == LEN_MAX) ? fill_q : fill_q + LEN_W'(1);
        pat_hit    = (fill_inc >= len_q) && (((hist_shift ^ pat_q) & mask) == '0);

        case (state_q)
            IDLE, DONE: begin
                cfg_take = cfg_we;
                if (start) begin
                    if ((len_q == '0) || (len_q > LEN_MAX)) begin
                        err_d = 1'b1;
                    end else begin
                        err_d   = 1'b0;
                        hit_d   = 1'b0;
                        cnt_d   = '0;
                        bits_d  = '0;
                        fill_d  = '0;
                        hist_d  = '0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (bit_valid) begin
                    hist_d = hist_shift;
                    bits_d = bits_q + WIN_W'(1);
                    fill_d = fill_inc;
                    if (pat_hit) begin
                        match_d = 1'b1;
                        if (cnt_q != {CNT_W{1'b1}}) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                        // Non-overlapping: the matched bits may not seed the next match
                        if (!ovl_q) begin
                            fill_d = '0;
                        end
                        if ((thr_q != '0) && (cnt_d >= thr_q)) begin
                            hit_d = 1'b1;
                        end
                    end
                    if ((win_q != '0) && (bits_d == win_q)) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, shadow configuration and run registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            win_q   <= '0;
            thr_q   <= '0;
            hist_q  <= '0;
            fill_q  <= '0;
            bits_q  <= '0;
            cnt_q   <= '0;
            match_q <= 1'b0;
            hit_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            bits_q  <= bits_d;
            cnt_q   <= cnt_d;
            match_q <= match_d;
            hit_q   <= hit_d;
            err_q   <= err_d;
            if (cfg_take) begin
                pat_q <= cfg_pattern;
                len_q <= cfg_len;
                ovl_q <= cfg_overlap;
                win_q <= cfg_window;
                thr_q <= cfg_thresh;
            end
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign match       = match_q;
    assign hit         = hit_q;
    assign match_count = cnt_q;
    assign err         = err_q;

`ifdef SEQ_DET_IRQ_EN
    logic irq_q;
    logic irq_set;

    assign irq_set = ((state_d == DONE) && (state_q != DONE)) || (hit_d && !hit_q);

    // Sticky interrupt: set on DONE entry or hit rise, set beats clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else if (irq_set) begin
            irq_q <= 1'b1;
        end else if (irq_clr) begin
            irq_q <= 1'b0;
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb/tb_seq_det_ctrl.sv - self-checking bench for seq_det_ctrl with a queue-based reference model
module tb_seq_det_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_we = 1'b0;
    logic [7:0] cfg_pattern = '0;
    logic [3:0] cfg_len = '0;
    logic       cfg_overlap = 1'b0;
    logic [11:0] cfg_window = '0;
    logic [7:0] cfg_thresh = '0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       bit_valid = 1'b0;
    logic       bit_in = 1'b0;
    logic       busy, done, match, hit, err;
    logic [7:0] match_count;
`ifdef SEQ_DET_IRQ_EN
    logic       irq_clr = 1'b0;
    logic       irq;
`endif

    int tests = 0;
    int fails = 0;

    seq_det_ctrl #(.PAT_W(8), .WIN_W(12), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_window(cfg_window),
        .cfg_thresh(cfg_thresh), .start(start), .abort(abort),
        .bit_valid(bit_valid), .bit_in(bit_in), .busy(busy), .done(done),
        .match(match), .hit(hit), .match_count(match_count), .err(err)
`ifdef SEQ_DET_IRQ_EN
        , .irq_clr(irq_clr), .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: 0 idle, 1 running, 2 finished
    int   m_mode;
    int   m_cnt;
    bit   m_hit, m_err, m_match;
    bit   m_irq;
    bit [7:0] s_pat;
    int   s_len, s_win, s_thr;
    bit   s_ovl;
    bit   q[$];
    int   mark;

    always @(posedge clk or posedge rst) begin
        int  n;
        bit  ok;
        bit  was_done;
        bit  hit_prev;
        if (rst) begin
            m_mode = 0; m_cnt = 0; m_hit = 0; m_err = 0; m_match = 0; m_irq = 0;
            s_pat = 0; s_len = 0; s_win = 0; s_thr = 0; s_ovl = 0;
            q.delete(); mark = 0;
        end else begin
            was_done = (m_mode == 2);
            hit_prev = m_hit;
            m_match = 0;
            if (m_mode != 1) begin
                if (start) begin
                    if (s_len == 0 || s_len > 8) m_err = 1;
                    else begin
                        m_err = 0; m_hit = 0; m_cnt = 0; q.delete(); mark = 0; m_mode = 1;
                    end
                end
                if (cfg_we) begin
                    s_pat = cfg_pattern; s_len = int'(cfg_len); s_ovl = cfg_overlap;
                    s_win = int'(cfg_window); s_thr = int'(cfg_thresh);
                end
            end else if (abort) begin
                m_mode = 0;
            end else if (bit_valid) begin
                q.push_back(bit_in);
                n = q.size();
                if (n - mark >= s_len) begin
                    ok = 1;
                    for (int k = 0; k < s_len; k++)
                        if (q[n - s_len + k] != s_pat[s_len - 1 - k]) ok = 0;
                    if (ok) begin
                        m_match = 1;
                        if (m_cnt < 255) m_cnt++;
                        if (!s_ovl) mark = n;
                        if (s_thr != 0 && m_cnt >= s_thr) m_hit = 1;
                    end
                end
                if (s_win != 0 && n == s_win) m_mode = 2;
            end
            if ((m_mode == 2 && !was_done) || (m_hit && !hit_prev)) m_irq = 1;
`ifdef SEQ_DET_IRQ_EN
            else if (irq_clr) m_irq = 0;
`endif
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            chk("cyc_busy",  32'(busy),        32'(m_mode == 1));
            chk("cyc_done",  32'(done),        32'(m_mode == 2));
            chk("cyc_match", 32'(match),       32'(m_match));
            chk("cyc_count", 32'(match_count), 32'(m_cnt));
            chk("cyc_hit",   32'(hit),         32'(m_hit));
            chk("cyc_err",   32'(err),         32'(m_err));
`ifdef SEQ_DET_IRQ_EN
            chk("cyc_irq",   32'(irq),         32'(m_irq));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                       input logic [11:0] win, input logic [7:0] thr);
        cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl; cfg_window = win; cfg_thresh = thr;
        cfg_we = 1'b1;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1; step(); abort = 1'b0;
    endtask

    task automatic send(input logic b);
        bit_valid = 1'b1; bit_in = b; step(); bit_valid = 1'b0;
    endtask

    // Sends a stream first bit at the MSB and records which bits produced a match pulse
    task automatic send_stream(input logic [31:0] stream, input int len, output logic [31:0] seen);
        seen = '0;
        for (int i = 0; i < len; i++) begin
            send(stream[len - 1 - i]);
            seen[i] = match;
        end
    endtask

    initial begin
        logic [31:0] seen;
        step();
        chk("rst_busy",  32'(busy), 0);
        chk("rst_done",  32'(done), 0);
        chk("rst_match", 32'(match), 0);
        chk("rst_count", 32'(match_count), 0);
        chk("rst_hit",   32'(hit), 0);
        chk("rst_err",   32'(err), 0);
        step();
        rst = 1'b0;
        step();

        // Non-overlapping 1010 over a 10-bit window
        cfg(8'b0000_1010, 4'd4, 1'b0, 12'd10, 8'd0);
        pulse_start();
        send_stream(32'b1010101010, 10, seen);
        chk("t1_mask",  seen, 32'b0010001000);
        chk("t1_count", 32'(match_count), 2);
        chk("t1_done",  32'(done), 1);
        chk("t1_busy",  32'(busy), 0);
        chk("t1_hit",   32'(hit), 0);
`ifdef SEQ_DET_IRQ_EN
        chk("irq_done", 32'(irq), 1);
        irq_clr = 1'b1; step(); irq_clr = 1'b0;
        chk("irq_clr",  32'(irq), 0);
`endif

        // Same stream, overlapping; final-bit match still counted
        cfg(8'b0000_1010, 4'd4, 1'b1, 12'd10, 8'd0);
        pulse_start();
        send_stream(32'b1010101010, 10, seen);
        chk("t2_mask",  seen, 32'b1010101000);
        chk("t2_count", 32'(match_count), 4);
        chk("t2_done",  32'(done), 1);

        // 111 overlapping, threshold 2, unbounded window
        cfg(8'b0000_0111, 4'd3, 1'b1, 12'd0, 8'd2);
        pulse_start();
        send_stream(32'b11110, 5, seen);
        chk("t3_mask",  seen, 32'b01100);
        chk("t3_hit",   32'(hit), 1);
        chk("t3_busy",  32'(busy), 1);
        pulse_abort();
        chk("t3_idle",  32'(busy | done), 0);
        chk("t3_count", 32'(match_count), 2);
        chk("t3_hitkeep", 32'(hit), 1);
        send(1'b1);
        chk("t3_ign_bit", 32'(match_count), 2);

        // Invalid lengths raise err without starting
        cfg(8'b0000_1010, 4'd0, 1'b0, 12'd0, 8'd0);
        pulse_start();
        chk("t4_err0",  32'(err), 1);
        chk("t4_busy0", 32'(busy), 0);
        cfg(8'b0000_1010, 4'd9, 1'b0, 12'd0, 8'd0);
        pulse_start();
        chk("t4_err9",  32'(err), 1);
        cfg(8'b0000_1010, 4'd4, 1'b0, 12'd0, 8'd0);
        pulse_start();
        chk("t4_err_clr", 32'(err), 0);
        chk("t4_busy",    32'(busy), 1);
        chk("t4_hitclr",  32'(hit), 0);

        // Mid-run config write is ignored; start+abort aborts
        cfg(8'b0000_1111, 4'd4, 1'b0, 12'd0, 8'd0);
        send_stream(32'b1010, 4, seen);
        chk("t5_oldpat", seen, 32'b1000);
        start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
        chk("t5_sa_busy",  32'(busy), 0);
        chk("t5_sa_count", 32'(match_count), 1);

        // Asynchronous reset mid-run
        cfg(8'b0000_1010, 4'd4, 1'b0, 12'd0, 8'd0);
        pulse_start();
        send_stream(32'b1010, 4, seen);
        chk("t6_pre", 32'(match_count), 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_busy",  32'(busy), 0);
        chk("t6_rst_count", 32'(match_count), 0);
        chk("t6_rst_match", 32'(match), 0);
        chk("t6_rst_flags", 32'({done, hit, err}), 0);
        step();
        step();
        rst = 1'b0;
        step();

        // Full-width pattern, non-overlapping, 20-bit window
        cfg(8'hA5, 4'd8, 1'b0, 12'd20, 8'd0);
        pulse_start();
        send_stream(32'b1010_0101_1010_0101_0101, 20, seen);
        chk("t7_mask",  seen, 32'h0000_8080);
        chk("t7_count", 32'(match_count), 2);
        chk("t7_done",  32'(done), 1);

`ifdef SEQ_DET_IRQ_EN
        // Clear coinciding with hit rise: set wins
        irq_clr = 1'b1; step(); irq_clr = 1'b0;
        cfg(8'h01, 4'd1, 1'b0, 12'd0, 8'd1);
        pulse_start();
        irq_clr = 1'b1; send(1'b1); irq_clr = 1'b0;
        chk("irq_setwins", 32'(irq), 1);
        pulse_abort();
`endif

        // Match counter saturation
        cfg(8'h01, 4'd1, 1'b0, 12'd0, 8'd0);
        pulse_start();
        for (int i = 0; i < 260; i++) send(1'b1);
        chk("t8_sat",  32'(match_count), 255);
        chk("t8_busy", 32'(busy), 1);
        pulse_abort();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
